imem_fetch_ctrl: RTL and testbench
==================================

IMEM_FETCH_CTRL -- requirements
Module: imem_fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: byte address loaded into PC on reset.
REQ-002 Parameter IMEM_DEPTH, default 512: instruction memory depth in 32-bit words.
REQ-003 Parameter HALT_WORD, default 32'h0000_000C (syscall): instruction encoding that ends the run.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle pulse; begins fetching from the current PC.
REQ-007 imem_addr  output  32  word index to the instruction memory, equal to {2'b00, pc[31:2]}.
REQ-008 imem_rdata  input  32  instruction word, valid combinationally in the same cycle as imem_addr.
REQ-009 instr  output  32  registered instruction presented to decode.
REQ-010 instr_pc  output  32  byte address of instr.
REQ-011 instr_valid  output  1  instr and instr_pc are valid.
REQ-012 instr_ready  input  1  decode accepts instr this cycle.
REQ-013 redirect_valid  input  1  branch/jump taken; flush and refetch.
REQ-014 redirect_pc  input  32  byte target for redirect.
REQ-015 busy  output  1  high in RUN.
REQ-016 halted  output  1  high in HALT.
REQ-017 fault  output  1  high in FAULT.
REQ-018 fetch_count  output  32  count of accepted instructions (instr_valid && instr_ready).

Function
REQ-019 States: IDLE, RUN, HALT, FAULT; the encoding is free; busy/halted/fault decode directly from state.
REQ-020 IDLE: holds PC, instr_valid=0; start -> RUN; redirect_valid in IDLE loads redirect_pc into PC without leaving IDLE.
REQ-021 RUN load condition: (!instr_valid || instr_ready) && !redirect_valid; on load, instr<=imem_rdata, instr_pc<=pc, instr_valid<=1, pc<=pc+4.
REQ-022 RUN hold: instr_valid && !instr_ready && !redirect_valid -> instr, instr_pc, instr_valid, pc unchanged (no drop, no duplicate).
REQ-023 Redirect priority in RUN: redirect_valid overrides load/hold; instr_valid<=0, pc<=redirect_pc; first fetch from the target occurs the next cycle (1-cycle bubble).
REQ-024 Redirect and acceptance in the same cycle: the presented instr counts as accepted (fetch_count increments); the flush still applies.
REQ-025 Misaligned redirect (redirect_pc[1:0]!=0) in IDLE or RUN -> FAULT, instr_valid<=0, pc unchanged.
REQ-026 Out-of-range fetch: in RUN with the load condition true and pc[31:2] >= IMEM_DEPTH -> FAULT, no load, instr_valid<=0.
REQ-027 Halt: when a loaded word equals HALT_WORD, it is presented normally; no further loads; on its acceptance (and no redirect) -> HALT, instr_valid<=0.
REQ-028 Redirect while HALT_WORD is pending: the redirect wins; the HALT_WORD is flushed; stay RUN.
REQ-029 HALT and FAULT: absorbing; only reset exits; instr_valid=0; start and redirect ignored.
REQ-030 pc+4 wraps modulo 2^32; the range check in REQ-026 takes effect before any wrap matters.
REQ-031 fetch_count: +1 per accepted instruction, wraps at 2^32, holds in all other cycles.
REQ-032 imem_addr is combinational from pc at all times, including IDLE/HALT/FAULT.

Reset
REQ-033 On reset (any state, mid-handshake included): state=IDLE, pc=RESET_PC, instr=0, instr_pc=0, instr_valid=0, fetch_count=0; busy=halted=fault=0.
REQ-034 Reset has priority over start, redirect_valid, and instr_ready in the same cycle.

Verification
REQ-035 Memory words 0..3 = 22310000, 2008004B, 014A6020, 0000000C; reset, start, instr_ready=1 -> instr_pc sequence 0,4,8,C on consecutive cycles; HALT one cycle after 0000000C is accepted; fetch_count=4.
REQ-036 Backpressure: instr_ready=0 for 3 cycles while word 1 is presented -> instr=2008004B, instr_pc=4 stable for 3 cycles; imem_addr=2 held; then accepted exactly once.
REQ-037 Redirect: redirect_pc=0x20 while instr_pc=4 is valid -> next cycle instr_valid=0, imem_addr=8; the following cycle instr_pc=0x20.
REQ-038 Faults: redirect_pc=0x22 -> fault=1 next cycle; separately redirect_pc=0x800 with IMEM_DEPTH=512 -> fault=1 on the next load attempt, instr_valid=0.
REQ-039 Reset mid-operation: reset asserted with instr_valid=1 and fetch_count=7 -> next cycle IDLE, pc=0, instr_valid=0, fetch_count=0; start restarts from 0.
REQ-040 Same-cycle: redirect_valid with instr_ready=1 -> fetch_count increments, flush applied; in HALT, start plus redirect -> no state change.

Source files
------------

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller: one word per cycle from IMEM into a single registered decode slot.
// Latency: a fetch appears on instr one cycle after pc; redirects cost one bubble. Backpressure: instr_ready low holds the slot and pc.
module imem_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_DEPTH = 512,
  parameter logic [31:0] HALT_WORD  = 32'h0000_000C
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        busy,
  output logic        halted,
  output logic        fault,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HALT,
    S_FAULT
  } state_t;

  localparam logic [31:0] DEPTH_W = 32'(IMEM_DEPTH);

  state_t      state;
  logic [31:0] pc;

  logic accept;
  logic redirect_misaligned;
  logic halt_pending;
  logic slot_free;
  logic pc_in_range;

  assign accept              = instr_valid && instr_ready;
  assign redirect_misaligned = redirect_pc[1:0] != 2'b00;
  // A presented HALT_WORD blocks further loads until it is accepted or flushed.
  assign halt_pending        = instr_valid && (instr == HALT_WORD);
  assign slot_free           = !instr_valid || instr_ready;
  assign pc_in_range         = {2'b00, pc[31:2]} < DEPTH_W;

  assign imem_addr = {2'b00, pc[31:2]};
  assign busy      = (state == S_RUN);
  assign halted    = (state == S_HALT);
  assign fault     = (state == S_FAULT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      instr       <= 32'h0;
      instr_pc    <= 32'h0;
      instr_valid <= 1'b0;
      fetch_count <= 32'h0;
    end else begin
      // A handshake counts even when a redirect flushes the slot in the same cycle.
      if (accept) begin
        fetch_count <= fetch_count + 32'd1;
      end

      case (state)
        S_IDLE: begin
          if (redirect_valid && redirect_misaligned) begin
            state <= S_FAULT;
          end else begin
            if (redirect_valid) begin
              pc <= redirect_pc;
            end
            if (start) begin
              state <= S_RUN;
            end
          end
        end

        S_RUN: begin
          if (redirect_valid) begin
            instr_valid <= 1'b0;
            if (redirect_misaligned) begin
              state <= S_FAULT;
            end else begin
              pc <= redirect_pc;
            end
          end else if (halt_pending) begin
            if (instr_ready) begin
              state       <= S_HALT;
              instr_valid <= 1'b0;
            end
          end else if (slot_free) begin
            if (!pc_in_range) begin
              state       <= S_FAULT;
              instr_valid <= 1'b0;
            end else begin
              instr       <= imem_rdata;
              instr_pc    <= pc;
              instr_valid <= 1'b1;
              pc          <= pc + 32'd4;
            end
          end
        end

        default: begin
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: directed scenarios plus a randomized stream checked against an in-order fetch scoreboard.
module tb_imem_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy;
  logic        halted;
  logic        fault;
  logic [31:0] fetch_count;

  logic [31:0] mem [512];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign imem_rdata = (imem_addr < 32'd512) ? mem[imem_addr[8:0]] : 32'hDEAD_BEEF;

  imem_fetch_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .busy           (busy),
    .halted         (halted),
    .fault          (fault),
    .fetch_count    (fetch_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    start          = 1'b0;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic load_program();
    for (int i = 0; i < 512; i++) mem[i] = 32'hA000_0000 | 32'(i);
    mem[0] = 32'h2231_0000;
    mem[1] = 32'h2008_004B;
    mem[2] = 32'h014A_6020;
    mem[3] = 32'h0000_000C;
  endtask

  task automatic start_run();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    load_program();
    do_reset();
    n_cmp++; if (busy !== 1'b0 || halted !== 1'b0 || fault !== 1'b0) begin n_err++; $display("FAIL reset_flags: got busy=%0d halted=%0d fault=%0d want 0/0/0", busy, halted, fault); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0d want 0", instr_valid); end
    n_cmp++; if (fetch_count !== 32'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", fetch_count); end
    n_cmp++; if (imem_addr !== 32'd0 || instr !== 32'd0 || instr_pc !== 32'd0) begin n_err++; $display("FAIL reset_regs: got addr=%h instr=%h pc=%h want 0", imem_addr, instr, instr_pc); end
  endtask

  task automatic test_program();
    load_program();
    do_reset();
    instr_ready = 1'b1;
    start_run();
    n_cmp++; if (busy !== 1'b1 || instr_valid !== 1'b0) begin n_err++; $display("FAIL prog_start: got busy=%0d valid=%0d want 1/0", busy, instr_valid); end
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 32'(4 * i) || instr !== mem[i]) begin n_err++; $display("FAIL prog_seq%0d: got valid=%0d pc=%h instr=%h want 1 %h %h", i, instr_valid, instr_pc, instr, 32'(4 * i), mem[i]); end
    end
    step();
    n_cmp++; if (halted !== 1'b1 || busy !== 1'b0 || instr_valid !== 1'b0) begin n_err++; $display("FAIL prog_halt: got halted=%0d busy=%0d valid=%0d want 1/0/0", halted, busy, instr_valid); end
    n_cmp++; if (fetch_count !== 32'd4) begin n_err++; $display("FAIL prog_count: got %0d want 4", fetch_count); end
    start          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    step();
    start          = 1'b0;
    redirect_valid = 1'b0;
    n_cmp++; if (halted !== 1'b1 || instr_valid !== 1'b0 || imem_addr !== 32'd4) begin n_err++; $display("FAIL halt_absorb: got halted=%0d valid=%0d addr=%h want 1/0/4", halted, instr_valid, imem_addr); end
  endtask

  task automatic test_backpressure();
    load_program();
    do_reset();
    instr_ready = 1'b1;
    start_run();
    step();
    step();
    instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (instr_valid !== 1'b1 || instr !== 32'h2008_004B || instr_pc !== 32'h4 || imem_addr !== 32'd2) begin n_err++; $display("FAIL bp_hold%0d: got valid=%0d instr=%h pc=%h addr=%h want 1 2008004b 4 2", i, instr_valid, instr, instr_pc, imem_addr); end
      step();
    end
    instr_ready = 1'b1;
    step();
    n_cmp++; if (instr_pc !== 32'h8 || instr !== 32'h014A_6020 || fetch_count !== 32'd2) begin n_err++; $display("FAIL bp_release: got pc=%h instr=%h count=%0d want 8 014a6020 2", instr_pc, instr, fetch_count); end
  endtask

  task automatic test_redirect();
    load_program();
    do_reset();
    instr_ready = 1'b1;
    start_run();
    step();
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h20;
    step();
    redirect_valid = 1'b0;
    n_cmp++; if (instr_valid !== 1'b0 || imem_addr !== 32'd8 || busy !== 1'b1) begin n_err++; $display("FAIL redir_bubble: got valid=%0d addr=%h busy=%0d want 0 8 1", instr_valid, imem_addr, busy); end
    n_cmp++; if (fetch_count !== 32'd2) begin n_err++; $display("FAIL redir_count: got %0d want 2", fetch_count); end
    step();
    n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 32'h20 || instr !== mem[8]) begin n_err++; $display("FAIL redir_target: got valid=%0d pc=%h instr=%h want 1 20 %h", instr_valid, instr_pc, instr, mem[8]); end
  endtask

  task automatic test_halt_redirect();
    bit found;
    load_program();
    do_reset();
    instr_ready = 1'b1;
    start_run();
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (instr_valid === 1'b1 && instr_pc === 32'hC) found = 1'b1;
    end
    instr_ready = 1'b0;
    n_cmp++; if (!found) begin n_err++; $display("FAIL hr_reach: got no halt word presented want pc c within 10 cycles"); end
    step();
    n_cmp++; if (instr_valid !== 1'b1 || instr !== 32'hC || imem_addr !== 32'd4 || busy !== 1'b1) begin n_err++; $display("FAIL hr_pending: got valid=%0d instr=%h addr=%h busy=%0d want 1 c 4 1", instr_valid, instr, imem_addr, busy); end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h10;
    step();
    redirect_valid = 1'b0;
    n_cmp++; if (busy !== 1'b1 || halted !== 1'b0 || instr_valid !== 1'b0) begin n_err++; $display("FAIL hr_flush: got busy=%0d halted=%0d valid=%0d want 1/0/0", busy, halted, instr_valid); end
    step();
    n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 32'h10 || instr !== mem[4] || fetch_count !== 32'd3) begin n_err++; $display("FAIL hr_refetch: got valid=%0d pc=%h instr=%h count=%0d want 1 10 %h 3", instr_valid, instr_pc, instr, fetch_count, mem[4]); end
  endtask

  task automatic test_faults();
    load_program();
    do_reset();
    instr_ready = 1'b1;
    start_run();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h22;
    step();
    redirect_valid = 1'b0;
    n_cmp++; if (fault !== 1'b1 || busy !== 1'b0 || instr_valid !== 1'b0 || imem_addr !== 32'd0) begin n_err++; $display("FAIL misalign: got fault=%0d busy=%0d valid=%0d addr=%h want 1/0/0/0", fault, busy, instr_valid, imem_addr); end
    start          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    step();
    start          = 1'b0;
    redirect_valid = 1'b0;
    n_cmp++; if (fault !== 1'b1 || busy !== 1'b0 || imem_addr !== 32'd0) begin n_err++; $display("FAIL fault_absorb: got fault=%0d busy=%0d addr=%h want 1/0/0", fault, busy, imem_addr); end

    do_reset();
    instr_ready    = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h800;
    step();
    redirect_valid = 1'b0;
    n_cmp++; if (busy !== 1'b0 || fault !== 1'b0 || imem_addr !== 32'h200) begin n_err++; $display("FAIL idle_redir: got busy=%0d fault=%0d addr=%h want 0/0/200", busy, fault, imem_addr); end
    start_run();
    step();
    n_cmp++; if (fault !== 1'b1 || instr_valid !== 1'b0 || fetch_count !== 32'd0) begin n_err++; $display("FAIL range: got fault=%0d valid=%0d count=%0d want 1/0/0", fault, instr_valid, fetch_count); end
  endtask

  task automatic test_reset_mid();
    bit found;
    load_program();
    mem[3] = 32'h0000_0001;
    do_reset();
    instr_ready = 1'b1;
    start_run();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (fetch_count === 32'd7 && instr_valid === 1'b1) found = 1'b1;
    end
    n_cmp++; if (!found) begin n_err++; $display("FAIL rm_reach: got count=%0d want 7 with valid within 20 cycles", fetch_count); end
    reset          = 1'b1;
    start          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    step();
    reset          = 1'b0;
    start          = 1'b0;
    redirect_valid = 1'b0;
    n_cmp++; if (busy !== 1'b0 || halted !== 1'b0 || fault !== 1'b0 || instr_valid !== 1'b0) begin n_err++; $display("FAIL rm_state: got busy=%0d halted=%0d fault=%0d valid=%0d want 0/0/0/0", busy, halted, fault, instr_valid); end
    n_cmp++; if (fetch_count !== 32'd0 || imem_addr !== 32'd0 || instr_pc !== 32'd0 || instr !== 32'd0) begin n_err++; $display("FAIL rm_regs: got count=%0d addr=%h pc=%h instr=%h want 0", fetch_count, imem_addr, instr_pc, instr); end
    start_run();
    step();
    n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 32'd0 || instr !== mem[0]) begin n_err++; $display("FAIL rm_restart: got valid=%0d pc=%h instr=%h want 1 0 %h", instr_valid, instr_pc, instr, mem[0]); end
    mem[3] = 32'h0000_000C;
  endtask

  // Scoreboard: accepted instructions must follow the architectural address stream
  // (sequential, or the most recent redirect target) and carry the memory word at that address.
  task automatic test_random();
    logic [31:0] exp_next;
    logic [31:0] held_instr;
    logic [31:0] held_pc;
    logic [31:0] tgt;
    int          cnt;
    bit          prev_hold;
    bit          prev_redir;
    bit          rdy;
    bit          redir;
    for (int i = 0; i < 512; i++) begin
      mem[i] = $urandom;
      if (mem[i] == 32'h0000_000C) mem[i] = 32'h0000_000D;
    end
    do_reset();
    start_run();
    exp_next   = 32'h0;
    cnt        = 0;
    prev_hold  = 1'b0;
    prev_redir = 1'b0;
    held_instr = 32'h0;
    held_pc    = 32'h0;
    for (int c = 0; c < 400; c++) begin
      n_cmp++; if (fetch_count !== 32'(cnt) || busy !== 1'b1) begin n_err++; $display("FAIL rnd_count c%0d: got count=%0d busy=%0d want %0d 1", c, fetch_count, busy, cnt); end
      if (prev_redir) begin
        n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL rnd_bubble c%0d: got valid=%0d want 0", c, instr_valid); end
      end
      if (prev_hold) begin
        n_cmp++; if (instr_valid !== 1'b1 || instr !== held_instr || instr_pc !== held_pc) begin n_err++; $display("FAIL rnd_hold c%0d: got valid=%0d instr=%h pc=%h want 1 %h %h", c, instr_valid, instr, instr_pc, held_instr, held_pc); end
      end
      rdy   = ($urandom_range(0, 9) < 7);
      redir = ($urandom_range(0, 15) == 0);
      tgt   = 32'($urandom_range(0, 63)) << 2;
      instr_ready    = rdy;
      redirect_valid = redir;
      redirect_pc    = tgt;
      if (instr_valid === 1'b1 && rdy) begin
        n_cmp++; if (instr_pc !== exp_next || instr !== mem[instr_pc[10:2]]) begin n_err++; $display("FAIL rnd_accept c%0d: got pc=%h instr=%h want %h %h", c, instr_pc, instr, exp_next, mem[exp_next[10:2]]); end
        cnt++;
        exp_next = exp_next + 32'd4;
      end
      prev_hold  = (instr_valid === 1'b1) && !rdy && !redir;
      held_instr = instr;
      held_pc    = instr_pc;
      prev_redir = redir;
      if (redir) exp_next = tgt;
      step();
    end
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    n_cmp++; if (fetch_count !== 32'(cnt)) begin n_err++; $display("FAIL rnd_final: got count=%0d want %0d", fetch_count, cnt); end
  endtask

  initial begin
    reset          = 1'b1;
    start          = 1'b0;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    test_reset();
    test_program();
    test_backpressure();
    test_redirect();
    test_halt_redirect();
    test_faults();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000 want finish");
    $fatal(1);
  end

endmodule
